move_entry: RTL and testbench

Upstream input stage of the board-game controller. Conditions the three raw push-buttons with synchronisation, debouncing and edge detection. Assembles a 4-bit row (y) and a 4-bit column (x) from single-bit presses. Range-checks the result against the 10x10 board and offers it to the game state machine over a valid/ready handshake. The downstream controller therefore receives only clean, complete, in-range coordinates and handles occupancy and win logic alone.

---
 rtl/move_entry_pkg.sv | 15 +
 rtl/move_entry_button_debounce.sv | 59 +++++
 rtl/move_entry.sv | 131 +++++++++++++
 tb/tb_move_entry.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/move_entry_pkg.sv
// Shared types and sizing for the move-entry input stage.
// Board geometry and the entry FSM state encoding live here.
package move_entry_pkg;

  localparam int COORD_W       = 4;
  localparam int BITS_PER_MOVE = 8;
  localparam int BOARD_SIZE    = 10;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    ARMED = 2'd1,
    OFFER = 2'd2
  } state_e;

endpackage

// File: rtl/move_entry_button_debounce.sv
// One push-button conditioner: two-flop synchroniser, stability counter,
// debounced level and a one-cycle pulse on each press (never on release).
module button_debounce #(
  parameter int DB_CYCLES          = 500000,
  parameter bit BUTTON_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);

  // Normalised so that 1 always means pressed; released therefore resets to 0.
  logic raw_n;
  assign raw_n = BUTTON_ACTIVE_HIGH ? btn_raw : ~btn_raw;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    sync1_d = raw_n;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES)) begin
        db_d    = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/move_entry.sv
// Move-entry stage: builds an LSB-first row/column from single-bit presses,
// range-checks it on commit and offers it downstream over valid/ready.
module move_entry
  import move_entry_pkg::*;
#(
  parameter int DB_CYCLES          = 500000,
  parameter bit BUTTON_ACTIVE_HIGH = 1'b1,
  parameter int COORD_MAX          = BOARD_SIZE - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               logic_0_button,
  input  logic               logic_1_button,
  input  logic               activity_button,
  output logic               move_valid,
  input  logic               move_ready,
  output logic [COORD_W-1:0] move_y,
  output logic [COORD_W-1:0] move_x,
  output logic [3:0]         entry_count,
  output logic               range_err,
  output state_e             state_dbg
);

  // Handshake: move_valid rises only with a stable move_y/move_x, stays high
  // until an edge sees move_valid & move_ready, and only reset drops it early.

  localparam logic [COORD_W-1:0] MAX_C   = COORD_W'(COORD_MAX);
  localparam logic [3:0]         LAST_IX = 4'(BITS_PER_MOVE - 1);

  logic p0, p1, pa;

  button_debounce #(.DB_CYCLES(DB_CYCLES), .BUTTON_ACTIVE_HIGH(BUTTON_ACTIVE_HIGH))
    u_db_l0 (.clk(clk), .rst(rst), .btn_raw(logic_0_button), .press(p0));
  button_debounce #(.DB_CYCLES(DB_CYCLES), .BUTTON_ACTIVE_HIGH(BUTTON_ACTIVE_HIGH))
    u_db_l1 (.clk(clk), .rst(rst), .btn_raw(logic_1_button), .press(p1));
  button_debounce #(.DB_CYCLES(DB_CYCLES), .BUTTON_ACTIVE_HIGH(BUTTON_ACTIVE_HIGH))
    u_db_act (.clk(clk), .rst(rst), .btn_raw(activity_button), .press(pa));

  // Simultaneous logic presses are ambiguous and dropped; activity wins over both.
  logic bit_pulse, bit_val;
  assign bit_pulse = (p0 ^ p1) & ~pa;
  assign bit_val   = p1;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] y_q, y_d, x_q, x_d;
  logic [COORD_W-1:0] move_y_q, move_y_d, move_x_q, move_x_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               rerr_q, rerr_d;

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    x_d      = x_q;
    move_y_d = move_y_q;
    move_x_d = move_x_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    rerr_d   = 1'b0;
    case (state_q)
      ENTRY: begin
        if (pa) begin
          cnt_d = '0;
          y_d   = '0;
          x_d   = '0;
        end else if (bit_pulse) begin
          if (!cnt_q[2]) y_d[cnt_q[1:0]] = bit_val;
          else           x_d[cnt_q[1:0]] = bit_val;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_IX) state_d = ARMED;
        end
      end
      ARMED: begin
        if (pa) begin
          if ((y_q > MAX_C) || (x_q > MAX_C)) begin
            rerr_d  = 1'b1;
            cnt_d   = '0;
            y_d     = '0;
            x_d     = '0;
            state_d = ENTRY;
          end else begin
            move_y_d = y_q;
            move_x_d = x_q;
            valid_d  = 1'b1;
            state_d  = OFFER;
          end
        end
      end
      OFFER: begin
        if (valid_q && move_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          y_d     = '0;
          x_d     = '0;
          state_d = ENTRY;
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ENTRY;
      y_q      <= '0;
      x_q      <= '0;
      move_y_q <= '0;
      move_x_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      x_q      <= x_d;
      move_y_q <= move_y_d;
      move_x_q <= move_x_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      rerr_q   <= rerr_d;
    end
  end

  assign move_valid  = valid_q;
  assign move_y      = move_y_q;
  assign move_x      = move_x_q;
  assign entry_count = cnt_q;
  assign range_err   = rerr_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_move_entry.sv
// Directed bench for move_entry: an active-high and an active-low instance
// driven by the same abstract press stimulus.
module tb_move_entry;
  import move_entry_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic b0, b1, ba, ready;

  always #5 clk = ~clk;

  logic       h_valid, h_rerr, l_valid, l_rerr;
  logic [3:0] h_y, h_x, h_cnt, l_y, l_x, l_cnt;
  state_e     h_state, l_state;

  move_entry #(.DB_CYCLES(4), .BUTTON_ACTIVE_HIGH(1'b1)) dut_h (
    .clk(clk), .rst(rst),
    .logic_0_button(b0), .logic_1_button(b1), .activity_button(ba),
    .move_valid(h_valid), .move_ready(ready), .move_y(h_y), .move_x(h_x),
    .entry_count(h_cnt), .range_err(h_rerr), .state_dbg(h_state)
  );

  move_entry #(.DB_CYCLES(4), .BUTTON_ACTIVE_HIGH(1'b0)) dut_l (
    .clk(clk), .rst(rst),
    .logic_0_button(~b0), .logic_1_button(~b1), .activity_button(~ba),
    .move_valid(l_valid), .move_ready(ready), .move_y(l_y), .move_x(l_x),
    .entry_count(l_cnt), .range_err(l_rerr), .state_dbg(l_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Monitors: did valid ever rise, how many cycles was range_err high.
  bit mon_valid;
  int mon_rerr;
  always @(negedge clk) begin
    if (h_valid) mon_valid = 1'b1;
    if (h_rerr)  mon_rerr  = mon_rerr + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 = logic_0, 1 = logic_1, 2 = activity
  task automatic press(input int which);
    @(negedge clk);
    if (which == 0) b0 = 1'b1; else if (which == 1) b1 = 1'b1; else ba = 1'b1;
    step(12);
    b0 = 1'b0; b1 = 1'b0; ba = 1'b0;
    step(12);
  endtask

  task automatic enter_move(input logic [3:0] y, input logic [3:0] x);
    logic [7:0] bits;
    bits = {x, y};
    for (int i = 0; i < 8; i++) press(bits[i] ? 1 : 0);
  endtask

  task automatic count_xfers(input int cycles, output int n);
    n = 0;
    ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (h_valid && ready) n++;
      step(1);
    end
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; b0 = 1'b0; b1 = 1'b0; ba = 1'b0; ready = 1'b0;
    mon_valid = 1'b0; mon_rerr = 0;
    step(3);
    n_cmp++; if (h_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", h_valid); end
    n_cmp++; if ({h_y, h_x} !== 8'h00) begin n_bad++; $display("FAIL reset_coord got=%h exp=00", {h_y, h_x}); end
    n_cmp++; if (h_cnt !== 4'd0 || h_rerr !== 1'b0) begin n_bad++; $display("FAIL reset_cnt_err got=%0d/%b exp=0/0", h_cnt, h_rerr); end
    n_cmp++; if (h_state !== ENTRY) begin n_bad++; $display("FAIL reset_state got=%0d exp=%0d", h_state, ENTRY); end
    n_cmp++; if (l_valid !== 1'b0 || l_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_low got=%b/%0d exp=0/0", l_valid, l_cnt); end
    rst = 1'b0;
    step(20);
    n_cmp++; if (h_cnt !== 4'd0 || l_cnt !== 4'd0) begin n_bad++; $display("FAIL idle_no_press got=%0d/%0d exp=0/0", h_cnt, l_cnt); end
  endtask

  task automatic test_clean_entry();
    int n;
    logic held;
    mon_valid = 1'b0;
    press(1); press(1); press(0); press(0);
    n_cmp++; if (h_cnt !== 4'd4) begin n_bad++; $display("FAIL clean_cnt4 got=%0d exp=4", h_cnt); end
    press(0); press(1); press(0); press(0);
    n_cmp++; if (h_cnt !== 4'd8 || h_state !== ARMED) begin n_bad++; $display("FAIL clean_armed got=%0d/%0d exp=8/%0d", h_cnt, h_state, ARMED); end
    n_cmp++; if (mon_valid !== 1'b0) begin n_bad++; $display("FAIL clean_early_valid got=%b exp=0", mon_valid); end
    press(2);
    n_cmp++; if (h_valid !== 1'b1 || h_state !== OFFER) begin n_bad++; $display("FAIL clean_valid got=%b/%0d exp=1/%0d", h_valid, h_state, OFFER); end
    n_cmp++; if (h_y !== 4'd3 || h_x !== 4'd2) begin n_bad++; $display("FAIL clean_coord got=y%0d x%0d exp=y3 x2", h_y, h_x); end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin step(1); if (!h_valid) held = 1'b0; end
    n_cmp++; if (held !== 1'b1) begin n_bad++; $display("FAIL clean_hold got=%b exp=1", held); end
    count_xfers(6, n);
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL clean_xfers got=%0d exp=1", n); end
    n_cmp++; if (h_valid !== 1'b0 || h_cnt !== 4'd0 || h_state !== ENTRY) begin n_bad++; $display("FAIL clean_after got=%b/%0d/%0d exp=0/0/0", h_valid, h_cnt, h_state); end
    n_cmp++; if (h_y !== 4'd3 || h_x !== 4'd2) begin n_bad++; $display("FAIL clean_coord_hold got=y%0d x%0d exp=y3 x2", h_y, h_x); end
  endtask

  task automatic test_bounce();
    int n;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      b1 = ~b1;
      step(2);
    end
    b1 = 1'b1;
    step(12);
    b1 = 1'b0;
    step(12);
    n_cmp++; if (h_cnt !== 4'd1) begin n_bad++; $display("FAIL bounce_cnt got=%0d exp=1", h_cnt); end
    // Remaining bits give y = 1 only if the bounced bit landed in y[0]; x = 9 is the legal edge.
    press(0); press(0); press(0);
    press(1); press(0); press(0); press(1);
    ready = 1'b1;
    mon_valid = 1'b0;
    press(2);
    n_cmp++; if (mon_valid !== 1'b1 || h_valid !== 1'b0) begin n_bad++; $display("FAIL bounce_early_ready got=%b/%b exp=1/0", mon_valid, h_valid); end
    n_cmp++; if (h_y !== 4'd1 || h_x !== 4'd9) begin n_bad++; $display("FAIL bounce_coord got=y%0d x%0d exp=y1 x9", h_y, h_x); end
    ready = 1'b0;
    count_xfers(3, n);
    n_cmp++; if (n !== 0) begin n_bad++; $display("FAIL bounce_extra_xfer got=%0d exp=0", n); end
  endtask

  task automatic test_range();
    mon_valid = 1'b0; mon_rerr = 0;
    enter_move(4'd10, 4'd0);
    press(2);
    n_cmp++; if (mon_rerr !== 1) begin n_bad++; $display("FAIL range_pulse got=%0d exp=1", mon_rerr); end
    n_cmp++; if (h_cnt !== 4'd0 || h_state !== ENTRY) begin n_bad++; $display("FAIL range_cnt got=%0d/%0d exp=0/0", h_cnt, h_state); end
    n_cmp++; if (mon_valid !== 1'b0) begin n_bad++; $display("FAIL range_valid got=%b exp=0", mon_valid); end
  endtask

  task automatic test_clear_conflict();
    int n;
    for (int i = 0; i < 5; i++) press(1);
    n_cmp++; if (h_cnt !== 4'd5) begin n_bad++; $display("FAIL clear_pre got=%0d exp=5", h_cnt); end
    press(2);
    n_cmp++; if (h_cnt !== 4'd0) begin n_bad++; $display("FAIL clear_cnt got=%0d exp=0", h_cnt); end
    @(negedge clk);
    b0 = 1'b1; b1 = 1'b1;
    step(12);
    b0 = 1'b0; b1 = 1'b0;
    step(12);
    n_cmp++; if (h_cnt !== 4'd0) begin n_bad++; $display("FAIL conflict_cnt got=%0d exp=0", h_cnt); end
    enter_move(4'd0, 4'd0);
    press(1);
    n_cmp++; if (h_cnt !== 4'd8 || h_state !== ARMED) begin n_bad++; $display("FAIL armed_ignore got=%0d/%0d exp=8/%0d", h_cnt, h_state, ARMED); end
    press(2);
    press(1);
    n_cmp++; if (h_cnt !== 4'd8 || h_valid !== 1'b1 || h_y !== 4'd0 || h_x !== 4'd0) begin n_bad++; $display("FAIL offer_ignore got=%0d/%b y%0d x%0d exp=8/1 y0 x0", h_cnt, h_valid, h_y, h_x); end
    count_xfers(4, n);
    n_cmp++; if (n !== 1 || h_valid !== 1'b0) begin n_bad++; $display("FAIL offer_xfer got=%0d/%b exp=1/0", n, h_valid); end
  endtask

  task automatic test_reset_mid_offer();
    int n;
    enter_move(4'd5, 4'd7);
    press(2);
    n_cmp++; if (h_valid !== 1'b1 || h_y !== 4'd5 || h_x !== 4'd7) begin n_bad++; $display("FAIL mid_offer got=%b y%0d x%0d exp=1 y5 x7", h_valid, h_y, h_x); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (h_valid !== 1'b0 || l_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_valid got=%b/%b exp=0/0", h_valid, l_valid); end
    n_cmp++; if (h_cnt !== 4'd0 || h_state !== ENTRY) begin n_bad++; $display("FAIL async_rst_cnt got=%0d/%0d exp=0/0", h_cnt, h_state); end
    @(negedge clk);
    rst = 1'b0;
    step(4);
    enter_move(4'd9, 4'd4);
    press(2);
    n_cmp++; if (h_valid !== 1'b1 || h_y !== 4'd9 || h_x !== 4'd4) begin n_bad++; $display("FAIL post_rst_offer got=%b y%0d x%0d exp=1 y9 x4", h_valid, h_y, h_x); end
    count_xfers(4, n);
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL post_rst_xfer got=%0d exp=1", n); end
  endtask

  task automatic test_active_low();
    int n;
    enter_move(4'd3, 4'd2);
    n_cmp++; if (l_cnt !== 4'd8 || l_state !== ARMED) begin n_bad++; $display("FAIL low_armed got=%0d/%0d exp=8/%0d", l_cnt, l_state, ARMED); end
    press(2);
    n_cmp++; if (l_valid !== 1'b1 || l_y !== 4'd3 || l_x !== 4'd2) begin n_bad++; $display("FAIL low_offer got=%b y%0d x%0d exp=1 y3 x2", l_valid, l_y, l_x); end
    n_cmp++; if (l_rerr !== 1'b0) begin n_bad++; $display("FAIL low_rerr got=%b exp=0", l_rerr); end
    count_xfers(4, n);
    n_cmp++; if (l_valid !== 1'b0 || l_cnt !== 4'd0 || n !== 1) begin n_bad++; $display("FAIL low_xfer got=%b/%0d/%0d exp=0/0/1", l_valid, l_cnt, n); end
  endtask

  initial begin
    test_reset();
    test_clean_entry();
    test_bounce();
    test_range();
    test_clear_conflict();
    test_reset_mid_offer();
    test_active_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
